jh512_nonce_sched: RTL
======================

# jh512_nonce_sched

Work scheduler for the fully pipelined JH512 hasher. Accepts one job (1024-bit chaining state, 96-bit message tail, nonce range, 64-bit target), issues one nonce per clock into the hasher, tracks in-flight nonces with a tag pipeline matched to the hasher latency, and compares each returned hash against the target. Qualifying nonces are queued in a small result FIFO read with a valid/ready handshake.

## Interface
- LATENCY, 96, clocks from hs_data/hs_state sampled to matching hs_hash; must equal the attached hasher depth, ≥2
- FIFO_DEPTH, 4, result FIFO entries (power of two)
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- work_valid  in  1  job offered
- work_ready  out  1  high only in IDLE
- work_state  in  1024  chaining state for the job
- work_data  in  96  message tail, nonce excluded
- nonce_start  in  32  first nonce
- nonce_end  in  32  last nonce, inclusive
- target  in  64  unsigned threshold
- abort  in  1  stop issuing, drain, return to IDLE
- hs_state  out  1024  to hasher, held constant for the whole job
- hs_data  out  128  to hasher, {work_data, nonce}, nonce in [31:0]
- hs_hash  in  512  from hasher
- found_valid  out  1  FIFO not empty
- found_ready  in  1  consumer pops head
- found_nonce  out  32  FIFO head
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at end of job
- overflow  out  1  sticky: a hit was dropped; cleared only by reset or next job acceptance

## Operation
- FSM IDLE, ISSUE, DRAIN.
- IDLE: work_ready=1. On work_valid&work_ready edge: latch work_state, work_data, target, nonce_end; nonce←nonce_start; clear overflow; go ISSUE. abort ignored.
- ISSUE: each cycle hs_data carries current nonce and a tag {1, nonce} enters the tag pipeline. If nonce==nonce_end or abort: go DRAIN, else nonce←nonce+1 (mod 2^32).
- Range wraps: nonce_end<nonce_start issues through 0xFFFFFFFF, 0, … nonce_end. Issue count = (nonce_end−nonce_start mod 2^32)+1; start==end issues exactly one. abort in ISSUE: nonce issued that cycle is still tracked; nothing further issued.
- Tag pipeline: LATENCY-stage shift of {valid, nonce}, shifts every cycle, inserts valid=0 when not ISSUE. Output stage aligns with hs_hash.
- Hit: tag valid and hs_hash[511:448] ≤ target (unsigned) → push tag nonce into FIFO.
- FIFO: pop when found_valid&found_ready. Push into full FIFO without simultaneous pop: hit dropped, overflow←1. Push and pop same cycle when full: both succeed. FIFO content survives job end and new job acceptance.
- DRAIN: down-counter loaded with LATENCY; at 0, done=1 for that cycle and go IDLE. All in-flight tags compared before done.
- reset at any time: state IDLE, tags invalid, FIFO empty, counters 0; in-flight hasher results ignored.

## Timing
- Reset values: work_ready 1 (IDLE), busy 0, done 0, found_valid 0, found_nonce 0, overflow 0, hs_state 0, hs_data 0.
- Job accepted at edge T: hs_state valid from T+1; nonce_start on hs_data in cycle T+1; nonce k of job in cycle T+1+k.
- Nonce presented in cycle C is compared in cycle C+LATENCY; found_valid earliest in cycle C+LATENCY+1.
- Last issue in cycle L: DRAIN cycles L+1…L+LATENCY+1, done in cycle L+LATENCY+1, work_ready=1 from cycle L+LATENCY+2.
- Throughput: one nonce/clock in ISSUE; minimum job-to-job gap LATENCY+2 idle issue slots.
- found_nonce changes only on pop or push to empty FIFO.

## Test plan
- Reset then single job start=0x10, end=0x10, target=0xFFFF_FFFF_FFFF_FFFF, hasher model with LATENCY=96 -> exactly one hs_data with nonce 0x10 in cycle T+1, found_nonce=0x10 valid cycle T+98, done in cycle T+98.
- Range 0xFFFFFFFE..0x00000001, target=0 with model forcing hash[511:448]=0 only for nonce 0xFFFFFFFF -> 4 issues in order FFFFFFFE,FFFFFFFF,0,1; FIFO holds only 0xFFFFFFFF.
- Range 0..99, target all-ones, found_ready=0 -> FIFO holds 0..3, overflow=1 after the 5th hit; found_ready=1 during a full-FIFO hit -> no drop that cycle.
- abort asserted at issue of nonce 50 in range 0..999 -> last hs_data nonce 50, no tag beyond 50 compared, done exactly LATENCY+1 cycles later; work_valid held high during busy not accepted.
- reset asserted mid-ISSUE (nonce 20) -> next cycle work_ready=1, busy=0, found_valid=0; stale hashes returning afterwards produce no hits.
- Back-to-back jobs with work_valid held high -> second accepted first cycle work_ready=1, hs_state changes only after done, overflow cleared on acceptance.

Source files
------------

// File: rtl/jh512_nonce_sched.sv
// Nonce scheduler for a fully pipelined JH512 hasher: issues one nonce per clock,
// tracks in-flight nonces alongside the hasher and queues nonces whose hash meets the target.
module jh512_nonce_sched #(
    parameter int LATENCY    = 96,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          work_valid,
    output logic          work_ready,
    input  logic [1023:0] work_state,
    input  logic [95:0]   work_data,
    input  logic [31:0]   nonce_start,
    input  logic [31:0]   nonce_end,
    input  logic [63:0]   target,
    input  logic          abort,
    output logic [1023:0] hs_state,
    output logic [127:0]  hs_data,
    input  logic [511:0]  hs_hash,
    output logic          found_valid,
    input  logic          found_ready,
    output logic [31:0]   found_nonce,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] FIFO_ONE  = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    state_t state_reg, state_next;

    logic [1023:0]     work_state_reg;
    logic [95:0]       work_data_reg;
    logic [63:0]       target_reg;
    logic [31:0]       nonce_end_reg;
    logic [31:0]       nonce_reg, nonce_next;
    logic [CNT_W-1:0]  drain_cnt_reg, drain_cnt_next;
    logic              accept;
    logic              issue;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            nonce_reg     <= '0;
            drain_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            nonce_reg     <= nonce_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        nonce_next     = nonce_reg;
        drain_cnt_next = drain_cnt_reg;
        accept         = 1'b0;
        issue          = 1'b0;
        done           = 1'b0;
        work_ready     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                work_ready = 1'b1;
                if (work_valid) begin
                    accept     = 1'b1;
                    nonce_next = nonce_start;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issue = 1'b1;
                // The nonce on hs_data this cycle is issued even when aborting.
                if ((nonce_reg == nonce_end_reg) || abort) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = CNT_W'(LATENCY);
                end else begin
                    nonce_next = nonce_reg + 32'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_reg == '0) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    drain_cnt_next = drain_cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Job parameters are latched once and held for the whole job.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_state_reg <= '0;
            work_data_reg  <= '0;
            target_reg     <= '0;
            nonce_end_reg  <= '0;
        end else if (accept) begin
            work_state_reg <= work_state;
            work_data_reg  <= work_data;
            target_reg     <= target;
            nonce_end_reg  <= nonce_end;
        end
    end

    assign hs_state = work_state_reg;
    assign hs_data  = {work_data_reg, nonce_reg};
    assign busy     = (state_reg != ST_IDLE);

    // ------------------------------------------------------------------
    // Tag pipeline: stage LATENCY-1 lines up with hs_hash
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] tag_valid_chain;
    logic [31:0]        tag_nonce_chain [LATENCY];

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tag
            logic        stage_valid_reg;
            logic [31:0] stage_nonce_reg;
            logic        in_valid;
            logic [31:0] in_nonce;

            if (gi == 0) begin : g_head
                assign in_valid = issue;
                assign in_nonce = nonce_reg;
            end else begin : g_body
                assign in_valid = tag_valid_chain[gi-1];
                assign in_nonce = tag_nonce_chain[gi-1];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_valid_reg <= 1'b0;
                end else begin
                    stage_valid_reg <= in_valid;
                end
                stage_nonce_reg <= in_nonce;
            end

            assign tag_valid_chain[gi] = stage_valid_reg;
            assign tag_nonce_chain[gi] = stage_nonce_reg;
        end
    endgenerate

    logic        hit;
    logic [31:0] hit_nonce;
    logic        unused_hash_bits;

    assign hit              = tag_valid_chain[LATENCY-1] && (hs_hash[511:448] <= target_reg);
    assign hit_nonce        = tag_nonce_chain[LATENCY-1];
    assign unused_hash_bits = ^hs_hash[447:0];

    // ------------------------------------------------------------------
    // Result FIFO with a registered head word
    // ------------------------------------------------------------------
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;
    logic [31:0]      head_reg, head_next;
    logic             overflow_reg;
    logic             pop;
    logic             push;
    logic             drop;
    logic             full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full = (count_reg == FIFO_FULL);
    assign pop  = found_valid && found_ready;
    // A full FIFO still accepts a hit when the head leaves in the same cycle.
    assign push = hit && (!full || pop);
    assign drop = hit && full && !pop;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        head_next   = head_reg;
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (push && !pop) begin
            count_next = count_reg + FIFO_ONE;
        end else if (pop && !push) begin
            count_next = count_reg - FIFO_ONE;
        end
        if (pop) begin
            if (count_reg > FIFO_ONE) begin
                head_next = fifo_mem[ptr_inc(rd_ptr_reg)];
            end else if (push) begin
                head_next = hit_nonce;
            end
        end else if (push && (count_reg == '0)) begin
            head_next = hit_nonce;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= hit_nonce;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            head_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (accept) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign found_valid = (count_reg != '0);
    assign found_nonce = head_reg;
    assign overflow    = overflow_reg;

endmodule
